// File: rtl/rc4_keystream_ctrl.sv
// rc4_keystream_ctrl
// Sequencer for an external 256x8 RC4 state array (S-box). After a start pulse
// it fills the array with the identity permutation (INIT, 256 cycles) and runs
// the key schedule (KSA, 512 cycles). It then generates keystream bytes (PRGA,
// 5 cycles per byte) and hands each one downstream with a valid/ready handshake.
// The S-box reads combinationally. On the same edge, a write takes priority over
// a swap, and a swap exchanges S[raddr] and S[waddr].
//
// Ports
//   clk, n_rst              clock (rising edge), async active-low reset
//   start_i                 latch key_i and run INIT+KSA+PRGA (ignored while busy)
//   stop_i                  abort to IDLE (ignored in IDLE)
//   key_i                   key, byte k = key_i[8k+7:8k]
//   ks_ready_i/ks_valid_o   keystream handshake, ks_byte_o = keystream byte
//   busy_o                  sequencer not idle
//   sarr_*                  S-box control/address/data pins, sarr_rdata_i read data
module rc4_keystream_ctrl #(
  parameter int unsigned KEY_BYTES = 5
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic                   ks_ready_i,
  output logic                   ks_valid_o,
  output logic [7:0]             ks_byte_o,
  output logic                   busy_o,
  output logic [7:0]             sarr_waddr_o,
  output logic [7:0]             sarr_wdata_o,
  output logic [7:0]             sarr_raddr_o,
  output logic                   sarr_swap_o,
  output logic                   sarr_renable_o,
  output logic                   sarr_wenable_o,
  input  logic [7:0]             sarr_rdata_i
);

  localparam int unsigned KidxW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StKsaRd,
    StKsaSw,
    StPrgaRi,
    StPrgaRj,
    StPrgaSw,
    StPrgaRk,
    StPrgaOut
  } state_e;

  state_e                   state_q, state_d;
  logic [7:0]               i_q, i_d;
  logic [7:0]               j_q, j_d;
  logic [7:0]               si_q, si_d;
  logic [7:0]               sj_q, sj_d;
  logic [7:0]               ks_byte_q, ks_byte_d;
  logic [KidxW-1:0]         kidx_q, kidx_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;
  logic [7:0]               key_byte;

  assign key_byte = key_q[8*kidx_q +: 8];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      i_q       <= '0;
      j_q       <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      ks_byte_q <= '0;
      kidx_q    <= '0;
      key_q     <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      sj_q      <= sj_d;
      ks_byte_q <= ks_byte_d;
      kidx_q    <= kidx_d;
      key_q     <= key_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    i_d            = i_q;
    j_d            = j_q;
    si_d           = si_q;
    sj_d           = sj_q;
    ks_byte_d      = ks_byte_q;
    kidx_d         = kidx_q;
    key_d          = key_q;
    ks_valid_o     = 1'b0;
    sarr_waddr_o   = '0;
    sarr_wdata_o   = '0;
    sarr_raddr_o   = '0;
    sarr_swap_o    = 1'b0;
    sarr_renable_o = 1'b0;
    sarr_wenable_o = 1'b0;

    if (stop_i && (state_q != StIdle)) begin
      // Abort: everything quiet this cycle, indices left stale for the next start.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            key_d   = key_i;
            i_d     = '0;
            kidx_d  = '0;
            state_d = StInit;
          end
        end
        StInit: begin
          sarr_wenable_o = 1'b1;
          sarr_waddr_o   = i_q;
          sarr_wdata_o   = i_q;
          i_d            = i_q + 8'd1;
          if (i_q == 8'hFF) begin
            j_d     = '0;
            state_d = StKsaRd;
          end
        end
        StKsaRd: begin
          sarr_renable_o = 1'b1;
          sarr_raddr_o   = i_q;
          j_d            = j_q + sarr_rdata_i + key_byte;
          state_d        = StKsaSw;
        end
        StKsaSw: begin
          sarr_swap_o  = 1'b1;
          sarr_raddr_o = i_q;
          sarr_waddr_o = j_q;
          kidx_d       = (kidx_q == KidxW'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;
          i_d          = i_q + 8'd1;
          if (i_q == 8'hFF) begin
            j_d     = '0;
            state_d = StPrgaRi;
          end else begin
            state_d = StKsaRd;
          end
        end
        StPrgaRi: begin
          sarr_renable_o = 1'b1;
          sarr_raddr_o   = i_q + 8'd1;
          i_d            = i_q + 8'd1;
          si_d           = sarr_rdata_i;
          j_d            = j_q + sarr_rdata_i;
          state_d        = StPrgaRj;
        end
        StPrgaRj: begin
          sarr_renable_o = 1'b1;
          sarr_raddr_o   = j_q;
          sj_d           = sarr_rdata_i;
          state_d        = StPrgaSw;
        end
        StPrgaSw: begin
          // i == j is a harmless self-swap.
          sarr_swap_o  = 1'b1;
          sarr_raddr_o = i_q;
          sarr_waddr_o = j_q;
          state_d      = StPrgaRk;
        end
        StPrgaRk: begin
          sarr_renable_o = 1'b1;
          sarr_raddr_o   = si_q + sj_q;
          ks_byte_d      = sarr_rdata_i;
          state_d        = StPrgaOut;
        end
        StPrgaOut: begin
          ks_valid_o = 1'b1;
          if (ks_ready_i) begin
            state_d = StPrgaRi;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign ks_byte_o = ks_byte_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_rc4_keystream_ctrl.sv
module tb_rc4_keystream_ctrl;

  localparam int unsigned KB = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [8*KB-1:0] key_i = '0;
  logic          ks_ready_i = 1'b0;
  logic          ks_valid_o;
  logic [7:0]    ks_byte_o;
  logic          busy_o;
  logic [7:0]    sarr_waddr_o, sarr_wdata_o, sarr_raddr_o, sarr_rdata_i;
  logic          sarr_swap_o, sarr_renable_o, sarr_wenable_o;

  int            total = 0;
  int            bad = 0;
  int            xfer_cnt = 0;
  logic [7:0]    exp_q[$];

  localparam logic [23:0] KeyKey = 24'h79654B;  // "Key", first char in low byte
  logic [7:0]    key_vec [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};

  rc4_keystream_ctrl #(.KEY_BYTES(KB)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .key_i          (key_i),
    .ks_ready_i     (ks_ready_i),
    .ks_valid_o     (ks_valid_o),
    .ks_byte_o      (ks_byte_o),
    .busy_o         (busy_o),
    .sarr_waddr_o   (sarr_waddr_o),
    .sarr_wdata_o   (sarr_wdata_o),
    .sarr_raddr_o   (sarr_raddr_o),
    .sarr_swap_o    (sarr_swap_o),
    .sarr_renable_o (sarr_renable_o),
    .sarr_wenable_o (sarr_wenable_o),
    .sarr_rdata_i   (sarr_rdata_i)
  );

  always #5 clk = ~clk;

  // S-box: combinational read, write beats swap, swap on the edge.
  logic [7:0] sbox [256];
  initial for (int k = 0; k < 256; k++) sbox[k] = 8'($urandom);
  assign sarr_rdata_i = sarr_renable_o ? sbox[sarr_raddr_o] : 8'h00;
  always @(posedge clk) begin
    if (sarr_wenable_o) begin
      sbox[sarr_waddr_o] <= sarr_wdata_o;
    end else if (sarr_swap_o) begin
      sbox[sarr_raddr_o] <= sbox[sarr_waddr_o];
      sbox[sarr_waddr_o] <= sbox[sarr_raddr_o];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Plain RC4: KSA then PRGA, n output bytes queued as expectations.
  function automatic void model_push(input logic [8*KB-1:0] key, input int n);
    int s[256];
    int i, j, t;
    for (int k = 0; k < 256; k++) s[k] = k;
    j = 0;
    for (int k = 0; k < 256; k++) begin
      j = (j + s[k] + int'(key[8*(k%KB) +: 8])) % 256;
      t = s[k]; s[k] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int b = 0; b < n; b++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      exp_q.push_back(8'(s[(s[i] + s[j]) % 256]));
    end
  endfunction

  // Monitor: scoreboard pop on each transfer, plus hold checks while stalled.
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_b = '0;
  always @(negedge clk) begin
    if (n_rst && !stop_i) begin
      if (prev_v && !prev_r) begin
        check("hold_valid", ks_valid_o, 1);
        check("hold_byte", ks_byte_o, prev_b);
      end
      if (ks_valid_o && ks_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte actual=%0h required=none", ks_byte_o);
        end else begin
          check("ks_byte", ks_byte_o, exp_q.pop_front());
        end
        xfer_cnt++;
      end
    end
    prev_v = ks_valid_o && n_rst && !stop_i;
    prev_r = ks_ready_i;
    prev_b = ks_byte_o;
  end

  task automatic launch(input logic [23:0] k, input logic with_stop);
    @(posedge clk);
    #1;
    key_i   = k;
    start_i = 1'b1;
    stop_i  = with_stop;
    @(posedge clk);  // E0
    #1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    key_i   = 24'($urandom);
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_valid(input int cnt0, input logic chk_lat);
    int c = cnt0;
    while (!ks_valid_o && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (chk_lat) check("latency", c, 772);
    else check("valid_seen", ks_valid_o, 1);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    ks_ready_i = 1'b0;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    stop_i = 1'b1;
    @(posedge clk);
    #1;
    stop_i = 1'b0;
    check("idle_busy", busy_o, 0);
    check("idle_valid", ks_valid_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] k;
    int c;
    int base;

    // Reset state
    #3;
    check("rst_valid", ks_valid_o, 0);
    check("rst_byte", ks_byte_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ctrl", {sarr_swap_o, sarr_renable_o, sarr_wenable_o}, 0);
    check("rst_addr", {sarr_waddr_o, sarr_raddr_o, sarr_wdata_o}, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Known vector, latency and byte rate
    ks_ready_i = 1'b1;
    for (int b = 0; b < 9; b++) exp_q.push_back(key_vec[b]);
    launch(KeyKey, 1'b0);
    wait_valid(0, 1'b1);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!ks_valid_o && c < 50);
    check("byte_period", c, 5);
    drain(200);
    go_idle();

    // Random keys: plain, start+stop together in IDLE, backpressure on byte 2
    for (int r = 0; r < 4; r++) begin
      k = 24'($urandom);
      ks_ready_i = 1'b1;
      model_push(k, 12);
      base = xfer_cnt;
      launch(k, (r == 1));
      if (r == 2) begin
        c = 0;
        while (!(ks_valid_o && xfer_cnt == base + 2) && c < 2000) begin
          @(posedge clk);
          #1;
          c++;
        end
        check("bp_reach", xfer_cnt - base, 2);
        ks_ready_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ks_ready_i = 1'b1;
      end else begin
        wait_valid(0, 1'b1);
      end
      drain(300);
      go_idle();
    end

    // Stop during KSA, then restart with a start pulse ignored during INIT
    ks_ready_i = 1'b1;
    launch(KeyKey, 1'b0);
    repeat (399) @(posedge clk);
    #1;
    stop_i = 1'b1;
    @(negedge clk);
    check("stop_ctrl", {sarr_swap_o, sarr_renable_o, sarr_wenable_o}, 0);
    check("stop_valid", ks_valid_o, 0);
    @(posedge clk);
    #1;
    stop_i = 1'b0;
    check("stop_busy", busy_o, 0);
    for (int b = 0; b < 9; b++) exp_q.push_back(key_vec[b]);
    launch(KeyKey, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    key_i   = 24'($urandom);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_valid(6, 1'b1);
    drain(200);
    go_idle();

    // Async reset while in PRGA_SW, then a full rerun
    k = 24'($urandom);
    ks_ready_i = 1'b1;
    model_push(k, 3);
    launch(k, 1'b0);
    c = 0;
    while (exp_q.size() > 1 && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("pre_rst_bytes", exp_q.size(), 1);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!sarr_swap_o && c < 20);
    check("swap_seen", sarr_swap_o, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_valid", ks_valid_o, 0);
    check("arst_byte", ks_byte_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_ctrl", {sarr_swap_o, sarr_renable_o, sarr_wenable_o}, 0);
    check("arst_addr", {sarr_waddr_o, sarr_raddr_o, sarr_wdata_o}, 0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    k = 24'($urandom);
    model_push(k, 8);
    launch(k, 1'b0);
    wait_valid(0, 1'b1);
    drain(200);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
